// File: rtl/palette_pkg.sv
// Shared types and constants for the programmable 16-entry text-mode palette.
// Entries are 12-bit RGB, 4 bits per channel.
package palette_pkg;

  localparam int PAL_ENTRIES = 16;
  localparam int IDX_W       = 4;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    PH_R = 2'd0,
    PH_G = 2'd1,
    PH_B = 2'd2
  } phase_t;

  typedef enum logic {
    IDLE       = 1'b0,
    WAIT_BLANK = 1'b1
  } state_t;

  localparam logic SEL_INDEX = 1'b0;
  localparam logic SEL_DATA  = 1'b1;

  // Entry 0 sits in the least significant 12 bits.
  localparam logic [PAL_ENTRIES-1:0][11:0] DEFAULT_PAL = {
    12'h777, 12'h770, 12'h707, 12'h700,
    12'h077, 12'h070, 12'h007, 12'h555,
    12'hFFF, 12'hFF0, 12'hF0F, 12'hF00,
    12'h0FF, 12'h0F0, 12'h00F, 12'h000
  };

  function automatic logic [3:0] rgb_comp(input rgb_t e, input phase_t p);
    logic [3:0] c;
    c = e.r;
    case (p)
      PH_G:    c = e.g;
      PH_B:    c = e.b;
      default: c = e.r;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/palette_regfile.sv
// 16x12 palette storage, reset to the default colours; one write port, three
// combinational read ports (foreground, background, host); writes land at the clock edge.
module palette_regfile
  import palette_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  rgb_t             wdata_i,
  input  logic [IDX_W-1:0] fg_addr_i,
  input  logic [IDX_W-1:0] bg_addr_i,
  input  logic [IDX_W-1:0] host_addr_i,
  output rgb_t             fg_rdata_o,
  output rgb_t             bg_rdata_o,
  output rgb_t             host_rdata_o
);

  rgb_t mem_q [PAL_ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PAL_ENTRIES; i++) begin
        mem_q[i] <= rgb_t'(DEFAULT_PAL[i]);
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign fg_rdata_o   = mem_q[fg_addr_i];
  assign bg_rdata_o   = mem_q[bg_addr_i];
  assign host_rdata_o = mem_q[host_addr_i];

endmodule

// File: rtl/palette_dac_ctrl.sv
// DAC-style host port for the text palette plus a 1-cycle fg/bg -> RGB lookup.
// Pixels never stall; host_ready drops only while a finished triple waits for blanking.
module palette_dac_ctrl
  import palette_pkg::*;
#(
  parameter bit COMMIT_IN_BLANK = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       host_valid,
  output logic       host_ready,
  input  logic       host_we,
  input  logic       host_sel,
  input  logic [7:0] host_wdata,
  output logic [7:0] host_rdata,
  output logic       host_rvalid,
  input  logic       blank,
  input  logic       pix_valid,
  input  logic [3:0] fg,
  input  logic [3:0] bg,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B,
  output logic       out_valid
);

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       stage_r_q, stage_r_d;
  logic [3:0]       stage_g_q, stage_g_d;
  logic [3:0]       stage_b_q, stage_b_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic [7:0]       r_q, g_q, b_q;
  logic             out_valid_q;

  logic             pal_we;
  rgb_t             pal_wdata;
  rgb_t             fg_ent, bg_ent, host_ent;
  logic             accept;
  logic [3:0]       wnib;
  logic             unused_wdata;

  assign wnib         = host_wdata[3:0];
  assign unused_wdata = ^host_wdata[7:4];
  assign host_ready   = (state_q != WAIT_BLANK);
  assign accept       = host_valid && host_ready;

  palette_regfile u_regfile (
    .clk          (clk),
    .rst_n        (rst_n),
    .we_i         (pal_we),
    .waddr_i      (idx_q),
    .wdata_i      (pal_wdata),
    .fg_addr_i    (fg),
    .bg_addr_i    (bg),
    .host_addr_i  (idx_q),
    .fg_rdata_o   (fg_ent),
    .bg_rdata_o   (bg_ent),
    .host_rdata_o (host_ent)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    stage_r_d = stage_r_q;
    stage_g_d = stage_g_q;
    stage_b_d = stage_b_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    pal_we    = 1'b0;
    pal_wdata = '{r: stage_r_q, g: stage_g_q, b: stage_b_q};

    case (state_q)
      IDLE: begin
        if (accept && host_we && host_sel == SEL_INDEX) begin
          // Re-pointing the index abandons whatever was staged.
          idx_d   = wnib;
          phase_d = PH_R;
        end else if (accept && host_we) begin
          case (phase_q)
            PH_R: begin
              stage_r_d = wnib;
              phase_d   = PH_G;
            end
            PH_G: begin
              stage_g_d = wnib;
              phase_d   = PH_B;
            end
            default: begin
              stage_b_d = wnib;
              if (COMMIT_IN_BLANK) begin
                state_d = WAIT_BLANK;
              end else begin
                pal_we    = 1'b1;
                pal_wdata = '{r: stage_r_q, g: stage_g_q, b: wnib};
                idx_d     = idx_q + 4'd1;
                phase_d   = PH_R;
              end
            end
          endcase
        end else if (accept && host_sel == SEL_INDEX) begin
          rvalid_d = 1'b1;
          rdata_d  = {4'b0, idx_q};
        end else if (accept) begin
          rvalid_d = 1'b1;
          rdata_d  = {4'b0, rgb_comp(host_ent, phase_q)};
          case (phase_q)
            PH_R:    phase_d = PH_G;
            PH_G:    phase_d = PH_B;
            default: begin
              phase_d = PH_R;
              idx_d   = idx_q + 4'd1;
            end
          endcase
        end
      end
      default: begin
        // Evaluated only from the edge after the B write, so blank already
        // high at that point still costs one waiting cycle.
        if (blank) begin
          pal_we  = 1'b1;
          idx_d   = idx_q + 4'd1;
          phase_d = PH_R;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      phase_q   <= PH_R;
      idx_q     <= '0;
      stage_r_q <= '0;
      stage_g_q <= '0;
      stage_b_q <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      stage_r_q <= stage_r_d;
      stage_g_q <= stage_g_d;
      stage_b_q <= stage_b_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  // Lookup reads the pre-commit entry on a commit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= pix_valid;
      if (pix_valid) begin
        r_q <= {fg_ent.r, bg_ent.r};
        g_q <= {fg_ent.g, bg_ent.g};
        b_q <= {fg_ent.b, bg_ent.b};
      end else begin
        r_q <= '0;
        g_q <= '0;
        b_q <= '0;
      end
    end
  end

  assign host_rdata  = rdata_q;
  assign host_rvalid = rvalid_q;
  assign R           = r_q;
  assign G           = g_q;
  assign B           = b_q;
  assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_palette_dac_ctrl.sv
// Bench for palette_dac_ctrl: instance 0 commits immediately, instance 1 waits
// for blanking; expected pixels and read data are queued and matched on output.
module tb_palette_dac_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       blank;
  logic       hv [2];
  logic       hwe [2];
  logic       hsel [2];
  logic [7:0] hwd [2];
  logic       hrdy [2];
  logic       hrv [2];
  logic [7:0] hrd [2];
  logic       pv [2];
  logic [3:0] fgi [2];
  logic [3:0] bgi [2];
  logic [7:0] ro [2];
  logic [7:0] go [2];
  logic [7:0] bo [2];
  logic       ov [2];

  int n_vec = 0;
  int n_err = 0;

  logic [11:0] dflt [16];
  logic [11:0] mpal [2][16];
  logic [23:0] pix_q [$];
  logic [7:0]  rd_q [$];
  logic [23:0] mon_pe;
  logic [7:0]  mon_re;

  always #5 clk = ~clk;

  palette_dac_ctrl #(.COMMIT_IN_BLANK(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .host_valid(hv[0]), .host_ready(hrdy[0]), .host_we(hwe[0]), .host_sel(hsel[0]),
    .host_wdata(hwd[0]), .host_rdata(hrd[0]), .host_rvalid(hrv[0]),
    .blank(blank), .pix_valid(pv[0]), .fg(fgi[0]), .bg(bgi[0]),
    .R(ro[0]), .G(go[0]), .B(bo[0]), .out_valid(ov[0])
  );

  palette_dac_ctrl #(.COMMIT_IN_BLANK(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .host_valid(hv[1]), .host_ready(hrdy[1]), .host_we(hwe[1]), .host_sel(hsel[1]),
    .host_wdata(hwd[1]), .host_rdata(hrd[1]), .host_rvalid(hrv[1]),
    .blank(blank), .pix_valid(pv[1]), .fg(fgi[1]), .bg(bgi[1]),
    .R(ro[1]), .G(go[1]), .B(bo[1]), .out_valid(ov[1])
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic host_op(input int d, input logic we, input logic sel, input logic [7:0] wd);
    @(negedge clk);
    hv[d] = 1'b1; hwe[d] = we; hsel[d] = sel; hwd[d] = wd;
    @(negedge clk);
    hv[d] = 1'b0;
  endtask

  task automatic wr(input int d, input logic sel, input logic [7:0] wd);
    host_op(d, 1'b1, sel, wd);
  endtask

  task automatic rd(input int d, input logic sel, input logic [7:0] exp);
    rd_q.push_back(exp);
    host_op(d, 1'b0, sel, 8'h00);
  endtask

  task automatic pix(input int d, input logic [3:0] f, input logic [3:0] b);
    logic [11:0] ef, eb;
    ef = mpal[d][f];
    eb = mpal[d][b];
    @(negedge clk);
    pv[d] = 1'b1; fgi[d] = f; bgi[d] = b;
    pix_q.push_back({ef[11:8], eb[11:8], ef[7:4], eb[7:4], ef[3:0], eb[3:0]});
    @(negedge clk);
    pv[d] = 1'b0;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) mpal[d][i] = dflt[i];
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ov[d] === 1'b1) begin
        if (pix_q.size() == 0) chk("pix_unexpected", 32'd1, 32'd0);
        else begin
          mon_pe = pix_q.pop_front();
          chk("pix_rgb", {8'h0, ro[d], go[d], bo[d]}, {8'h0, mon_pe});
        end
      end
      if (hrv[d] === 1'b1) begin
        if (rd_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
        else begin
          mon_re = rd_q.pop_front();
          chk("rd_data", {24'h0, hrd[d]}, {24'h0, mon_re});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dflt = '{12'h000, 12'h00F, 12'h0F0, 12'h0FF, 12'hF00, 12'hF0F, 12'hFF0, 12'hFFF,
             12'h555, 12'h007, 12'h070, 12'h077, 12'h700, 12'h707, 12'h770, 12'h777};
    model_reset();
    rst_n = 1'b0;
    blank = 1'b0;
    for (int d = 0; d < 2; d++) begin
      hv[d] = 1'b0; hwe[d] = 1'b0; hsel[d] = 1'b0; hwd[d] = 8'h00;
      pv[d] = 1'b0; fgi[d] = 4'h0; bgi[d] = 4'h0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_rgb", {7'h0, ov[d], ro[d], go[d], bo[d]}, 32'h0);
      chk("rst_host", {22'h0, hrdy[d], hrv[d], hrd[d]}, {22'h0, 1'b1, 1'b0, 8'h00});
    end
    rst_n = 1'b1;

    // default lookup, then outputs return to zero
    pix(0, 4'd1, 4'd4);
    @(negedge clk);
    chk("pix_off", {7'h0, ov[0], ro[0], go[0], bo[0]}, 32'h0);

    // immediate commit
    wr(0, 1'b0, 8'h03);
    wr(0, 1'b1, 8'h0A); wr(0, 1'b1, 8'h0B); wr(0, 1'b1, 8'h0C);
    mpal[0][3] = 12'hABC;
    pix(0, 4'd3, 4'd0);
    rd(0, 1'b0, 8'h04);

    // blank-gated commit
    wr(1, 1'b0, 8'h02);
    wr(1, 1'b1, 8'h01); wr(1, 1'b1, 8'h02); wr(1, 1'b1, 8'h03);
    chk("wait_ready", {31'h0, hrdy[1]}, 32'h0);
    pix(1, 4'd2, 4'd0);
    chk("wait_ready_hold", {31'h0, hrdy[1]}, 32'h0);
    @(negedge clk); blank = 1'b1;
    @(negedge clk);
    chk("commit_ready", {31'h0, hrdy[1]}, 32'h1);
    blank = 1'b0;
    mpal[1][2] = 12'h123;
    pix(1, 4'd2, 4'd0);

    // blank already high when B is accepted: one waiting cycle still happens
    blank = 1'b1;
    wr(1, 1'b0, 8'h09);
    wr(1, 1'b1, 8'h04); wr(1, 1'b1, 8'h05); wr(1, 1'b1, 8'h06);
    chk("blank_hi_wait", {31'h0, hrdy[1]}, 32'h0);
    @(negedge clk);
    chk("blank_hi_commit", {31'h0, hrdy[1]}, 32'h1);
    blank = 1'b0;
    mpal[1][9] = 12'h456;
    pix(1, 4'd9, 4'd9);
    rd(1, 1'b0, 8'h0A);

    // index wrap
    wr(0, 1'b0, 8'h0F);
    wr(0, 1'b1, 8'h01); wr(0, 1'b1, 8'h02); wr(0, 1'b1, 8'h03);
    mpal[0][15] = 12'h123;
    rd(0, 1'b0, 8'h00);
    pix(0, 4'd15, 4'd15);

    // partial triple discarded by index write
    wr(0, 1'b0, 8'h05);
    wr(0, 1'b1, 8'h09);
    wr(0, 1'b0, 8'h06);
    wr(0, 1'b1, 8'h04); wr(0, 1'b1, 8'h05); wr(0, 1'b1, 8'h06);
    mpal[0][6] = 12'h456;
    pix(0, 4'd5, 4'd6);

    // readback of entry 8 (555)
    wr(0, 1'b0, 8'h08);
    rd(0, 1'b1, 8'h05); rd(0, 1'b1, 8'h05); rd(0, 1'b1, 8'h05);
    rd(0, 1'b0, 8'h09);

    // reset while waiting for blank
    wr(1, 1'b0, 8'h07);
    wr(1, 1'b1, 8'h01); wr(1, 1'b1, 8'h02); wr(1, 1'b1, 8'h03);
    chk("pre_rst_wait", {31'h0, hrdy[1]}, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'h0, hrdy[1]}, 32'h1);
    chk("mid_rst_out", {7'h0, ov[1], ro[1], go[1], bo[1]}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    blank = 1'b1;
    repeat (3) @(negedge clk);
    blank = 1'b0;
    pix(1, 4'd7, 4'd2);
    pix(0, 4'd3, 4'd1);
    rd(1, 1'b0, 8'h00);

    repeat (3) @(negedge clk);
    chk("pix_q_drained", pix_q.size(), 32'd0);
    chk("rd_q_drained", rd_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
